// File: rtl/harris_response.sv
// Harris corner response: 3x3 structure-tensor sums -> det - k*trace^2 -> threshold compare.
// Optional saturating corner counter is built when HARRIS_CORNER_COUNT_EN is defined.
module harris_response #(
  parameter int unsigned K_NUM   = 5,
  parameter int unsigned K_SHIFT = 7,
  parameter int unsigned R_W     = 48,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [197:0]            Ixx,
  input  logic [197:0]            Iyy,
  input  logic [197:0]            Ixy,
  input  logic signed [R_W-1:0]   threshold,
  input  logic                    clear_count,
  output logic                    Q,
  output logic signed [R_W-1:0]   R,
  output logic                    corner,
  output logic [CNT_W-1:0]        corner_count
);

  localparam logic signed [63:0] K_NUM_S = 64'(K_NUM);
  localparam logic signed [63:0] R_MAX   = (64'sd1 <<< (R_W - 1)) - 64'sd1;
  localparam logic signed [63:0] R_MIN   = -(64'sd1 <<< (R_W - 1));

  // Valid chain: sums -> det/tr2 -> det/kt -> output.
  logic v1_q, v2_q, v3_q, q_q;

  logic signed [25:0]    sxx_d, syy_d, sxy_d;
  logic signed [25:0]    sxx_q, syy_q, sxy_q;
  logic signed [R_W-1:0] thr1_q, thr2_q, thr3_q;

  logic signed [63:0]    sxx_w, syy_w, sxy_w, tr_w;
  logic signed [63:0]    det_d, tr2_d, det2_q, tr2_q;
  logic signed [63:0]    kt_d, det3_q, kt_q;

  logic signed [63:0]    rfull, thr_ext;
  logic signed [R_W-1:0] r_d, r_q;
  logic                  corner_d, corner_q;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    sxx_d = '0;
    syy_d = '0;
    sxy_d = '0;
    for (int i = 0; i < 9; i++) begin
      sxx_d = sxx_d + {{4{Ixx[22*i+21]}}, Ixx[22*i +: 22]};
      syy_d = syy_d + {{4{Iyy[22*i+21]}}, Iyy[22*i +: 22]};
      sxy_d = sxy_d + {{4{Ixy[22*i+21]}}, Ixy[22*i +: 22]};
    end
  end

  always_comb begin
    sxx_w = {{38{sxx_q[25]}}, sxx_q};
    syy_w = {{38{syy_q[25]}}, syy_q};
    sxy_w = {{38{sxy_q[25]}}, sxy_q};
    tr_w  = sxx_w + syy_w;
    det_d = sxx_w * syy_w - sxy_w * sxy_w;
    tr2_d = tr_w * tr_w;
    kt_d  = (K_NUM_S * tr2_q) >>> K_SHIFT;
  end

  // The k*trace^2 product is registered before the subtract so the
  // multiplier and the wide subtract/clip never share one cycle.
  always_comb begin
    rfull    = det3_q - kt_q;
    thr_ext  = {{(64 - R_W){thr3_q[R_W-1]}}, thr3_q};
    corner_d = rfull > thr_ext;
    if (rfull > R_MAX) begin
      r_d = R_MAX[R_W-1:0];
    end else if (rfull < R_MIN) begin
      r_d = R_MIN[R_W-1:0];
    end else begin
      r_d = rfull[R_W-1:0];
    end
  end

  // NOTE: non-blocking assignments keep every stage reading last cycle's value.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      q_q      <= 1'b0;
      r_q      <= '0;
      corner_q <= 1'b0;
    end else begin
      v1_q <= start;
      v2_q <= v1_q;
      v3_q <= v2_q;
      q_q  <= v3_q;
      if (v3_q) begin
        r_q      <= r_d;
        corner_q <= corner_d;
      end
    end
  end

  // NOTE: datapath registers carry no reset; the valid chain alone qualifies them.
  always_ff @(posedge clk) begin
    if (start) begin
      sxx_q  <= sxx_d;
      syy_q  <= syy_d;
      sxy_q  <= sxy_d;
      thr1_q <= threshold;
    end
    if (v1_q) begin
      det2_q <= det_d;
      tr2_q  <= tr2_d;
      thr2_q <= thr1_q;
    end
    if (v2_q) begin
      det3_q <= det2_q;
      kt_q   <= kt_d;
      thr3_q <= thr2_q;
    end
  end

  assign Q      = q_q;
  assign R      = r_q;
  assign corner = corner_q;

`ifdef HARRIS_CORNER_COUNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear has priority over a coincident increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (q_q && corner_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign corner_count = cnt_q;
`else
  logic unused_clear_count;
  assign unused_clear_count = clear_count;
  assign corner_count       = '0;
`endif

endmodule

// File: tb/tb_harris_response.sv
// Bench for harris_response: directed scenarios plus randomized vectors against an integer model.
// Counter expectations follow HARRIS_CORNER_COUNT_EN.
module tb_harris_response;
  localparam int R_W     = 48;
  localparam int CNT_W   = 4;
  localparam int K_NUM   = 5;
  localparam int K_SHIFT = 7;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam longint R_MAX_L = (longint'(1) << (R_W - 1)) - 1;
  localparam longint R_MIN_L = -(longint'(1) << (R_W - 1));
`ifdef HARRIS_CORNER_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  clear_count = 1'b0;
  logic [197:0]          ixx = '0, iyy = '0, ixy = '0;
  logic signed [R_W-1:0] threshold = '0;
  logic                  q, corner;
  logic signed [R_W-1:0] r;
  logic [CNT_W-1:0]      corner_count;

  harris_response #(.K_NUM(K_NUM), .K_SHIFT(K_SHIFT), .R_W(R_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .Ixx(ixx), .Iyy(iyy), .Ixy(ixy),
    .threshold(threshold), .clear_count(clear_count),
    .Q(q), .R(r), .corner(corner), .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; longint r; bit c;} res_t;
  res_t obs[$];
  res_t exp_q[$];
  int   total = 0, bad = 0, cyc = 0, exp_cnt = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (q) obs.push_back('{cyc, longint'(r), corner});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  function automatic logic [197:0] splat(input int v);
    logic [197:0] x;
    for (int i = 0; i < 9; i++) x[22*i +: 22] = 22'(v);
    return x;
  endfunction

  function automatic logic [197:0] rand_vec(input bit big);
    logic [197:0] x;
    int v;
    for (int i = 0; i < 9; i++) begin
      v = big ? int'($urandom) : int'($urandom_range(2000)) - 1000;
      x[22*i +: 22] = v[21:0];
    end
    return x;
  endfunction

  // R before clipping, from the textbook formula with floor division by 2^K_SHIFT.
  function automatic longint model_rfull(input logic [197:0] xx, yy, xy);
    longint sxx = 0, syy = 0, sxy = 0, tr2, kt;
    logic signed [21:0] e;
    for (int i = 0; i < 9; i++) begin
      e = xx[22*i +: 22]; sxx += longint'(e);
      e = yy[22*i +: 22]; syy += longint'(e);
      e = xy[22*i +: 22]; sxy += longint'(e);
    end
    tr2 = (sxx + syy) * (sxx + syy);
    kt  = (K_NUM * tr2) / (longint'(1) << K_SHIFT);
    return sxx * syy - sxy * sxy - kt;
  endfunction

  function automatic longint clip(input longint v);
    return (v > R_MAX_L) ? R_MAX_L : (v < R_MIN_L) ? R_MIN_L : v;
  endfunction

  task automatic send(input logic [197:0] xx, yy, xy, input longint th);
    longint rf;
    rf = model_rfull(xx, yy, xy);
    @(negedge clk);
    ixx = xx; iyy = yy; ixy = xy;
    threshold = th[R_W-1:0];
    start = 1'b1;
    exp_q.push_back('{cyc + 4, clip(rf), rf > th});
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    start = 1'b0;
    while (obs.size() < exp_q.size() && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    foreach (exp_q[i])
      if (exp_q[i].c && CNT_EN) exp_cnt = (exp_cnt < CNT_MAX) ? exp_cnt + 1 : CNT_MAX;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    obs.delete();
    exp_q.delete();
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (q !== 1'b0) begin bad++; $display("FAIL reset_q: got %0b want 0", q); end
    total++; if (r !== '0) begin bad++; $display("FAIL reset_r: got %0d want 0", r); end
    total++; if (corner !== 1'b0) begin bad++; $display("FAIL reset_corner: got %0b want 0", corner); end
    total++; if (corner_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", corner_count); end
    ixx = splat(100); iyy = splat(100); ixy = '0; start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (8) @(negedge clk);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL start_in_reset: got %0d pulses want 0", obs.size()); end
    obs.delete();
  endtask

  task automatic test_single(input string name, input int vxx, vyy, input longint th,
                             input longint want_r, input bit want_c);
    send(splat(vxx), splat(vyy), '0, th);
    drain();
    total++;
    if (obs.size() !== 1) begin
      bad++; $display("FAIL %s_pulses: got %0d want 1", name, obs.size());
    end else begin
      total++; if (obs[0].cyc !== exp_q[0].cyc) begin bad++; $display("FAIL %s_latency: got cyc %0d want %0d", name, obs[0].cyc, exp_q[0].cyc); end
      total++; if (obs[0].r !== want_r) begin bad++; $display("FAIL %s_r: got %0d want %0d", name, obs[0].r, want_r); end
      total++; if (obs[0].c !== want_c) begin bad++; $display("FAIL %s_corner: got %0b want %0b", name, obs[0].c, want_c); end
    end
    total++; if (int'(corner_count) !== exp_cnt) begin bad++; $display("FAIL %s_count: got %0d want %0d", name, corner_count, exp_cnt); end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    longint last;
    for (int i = 0; i < 5; i++) send(splat(100), (i % 2 == 0) ? splat(100) : '0, '0, 500000);
    last = exp_q[$].r;
    drain();
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL stream_pulses: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i].cyc !== exp_q[i].cyc || obs[i].r !== exp_q[i].r || obs[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL stream[%0d]: got cyc=%0d R=%0d c=%0b want cyc=%0d R=%0d c=%0b", i,
                 obs[i].cyc, obs[i].r, obs[i].c, exp_q[i].cyc, exp_q[i].r, exp_q[i].c);
      end
    end
    total++; if (longint'(r) !== last) begin bad++; $display("FAIL stream_hold: got %0d want %0d", r, last); end
    total++; if (int'(corner_count) !== exp_cnt) begin bad++; $display("FAIL stream_count: got %0d want %0d", corner_count, exp_cnt); end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    logic [197:0] xx, yy, xy;
    longint rf, th;
    for (int n = 0; n < 60; n++) begin
      xx = rand_vec($urandom_range(1) == 1);
      yy = rand_vec($urandom_range(1) == 1);
      xy = rand_vec($urandom_range(1) == 1);
      rf = model_rfull(xx, yy, xy);
      case ($urandom_range(3))
        0: th = clip(rf) - 1;
        1: th = clip(rf);
        2: th = clip(rf) + 1;
        default: th = longint'($urandom_range(2000000)) - 1000000;
      endcase
      th = clip(th);
      send(xx, yy, xy, th);
      if ($urandom_range(2) == 0) begin
        @(negedge clk);
        start = 1'b0;
      end
    end
    drain();
    total++; if (obs.size() !== exp_q.size()) begin bad++; $display("FAIL random_pulses: got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      total++;
      if (obs[i].cyc !== exp_q[i].cyc || obs[i].r !== exp_q[i].r || obs[i].c !== exp_q[i].c) begin
        bad++;
        $display("FAIL random[%0d]: got cyc=%0d R=%0d c=%0b want cyc=%0d R=%0d c=%0b", i,
                 obs[i].cyc, obs[i].r, obs[i].c, exp_q[i].cyc, exp_q[i].r, exp_q[i].c);
      end
    end
    total++; if (int'(corner_count) !== exp_cnt) begin bad++; $display("FAIL random_count: got %0d want %0d", corner_count, exp_cnt); end
    obs.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    send(splat(100), splat(100), '0, 500000);
    send(splat(100), '0, '0, -1000000);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    repeat (8) @(negedge clk);
    total++; if (obs.size() !== 0) begin bad++; $display("FAIL midflight_pulses: got %0d want 0", obs.size()); end
    total++; if (r !== '0) begin bad++; $display("FAIL midflight_r: got %0d want 0", r); end
    total++; if (corner !== 1'b0) begin bad++; $display("FAIL midflight_corner: got %0b want 0", corner); end
    total++; if (corner_count !== '0) begin bad++; $display("FAIL midflight_count: got %0d want 0", corner_count); end
    obs.delete();
  endtask

  task automatic test_counter_limits();
    int guard = 0;
    do_reset();
    for (int i = 0; i < 20; i++) send(splat(100), splat(100), '0, 500000);
    drain();
    total++; if (obs.size() !== 20) begin bad++; $display("FAIL sat_pulses: got %0d want 20", obs.size()); end
    total++; if (int'(corner_count) !== (CNT_EN ? CNT_MAX : 0)) begin bad++; $display("FAIL sat_count: got %0d want %0d", corner_count, CNT_EN ? CNT_MAX : 0); end
    obs.delete();
    exp_q.delete();
    send(splat(100), splat(100), '0, 500000);
    @(negedge clk);
    start = 1'b0;
    while (!q && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    total++; if (guard >= 10) begin bad++; $display("FAIL clear_wait: got no Q want Q within 10 cycles"); end
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (corner_count !== '0) begin bad++; $display("FAIL clear_vs_incr: got %0d want 0", corner_count); end
    obs.delete();
    exp_q.delete();
    exp_cnt = 0;
    send(splat(100), splat(100), '0, 500000);
    drain();
    total++; if (int'(corner_count) !== exp_cnt) begin bad++; $display("FAIL after_clear: got %0d want %0d", corner_count, exp_cnt); end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single("zero", 0, 0, 0, 0, 1'b0);
    test_single("corner", 100, 100, 500000, 683438, 1'b1);
    test_single("edge", 100, 0, 0, -31640, 1'b0);
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_counter_limits();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/harris_response.md
# harris_response

Downstream stage of the Sobel gradient block in the Harris corner path. Accepts the nine Ix², Iy² and IxIy products of a 3×3 neighbourhood, forms the structure tensor by summation, and computes the Harris response R = det(M) − k·trace(M)². It then flags the centre pixel as a corner when R exceeds a programmable threshold. The block is a fixed 3-stage valid-only pipeline with an optional saturating corner counter.

## Interface
- K_NUM, 5: numerator of k (unsigned, 1..255).
- K_SHIFT, 7: k = K_NUM / 2^K_SHIFT (0..15); default k ≈ 0.039.
- R_W, 48: output width of R (signed).
- CNT_W, 16: corner counter width.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  input valid; products sampled on this cycle.
- Ixx  in  9×22 packed (198)  signed Ix² products; element i at bits [22i+21:22i].
- Iyy  in  9×22 packed (198)  signed Iy² products; same packing.
- Ixy  in  9×22 packed (198)  signed IxIy products; same packing.
- threshold  in  R_W  signed corner threshold; sampled with start.
- clear_count  in  1  synchronous clear of corner_count.
- Q  out  1  output valid, one cycle per accepted input.
- R  out  R_W  signed Harris response, saturated.
- corner  out  1  R > threshold (strict, signed).
- corner_count  out  CNT_W  saturating count of corner=1 results.

## Operation
- Stage 1, on a start cycle:
  - Sxx = ΣIxx[i], Syy = ΣIyy[i], Sxy = ΣIxy[i] over i = 0..8, each 26-bit signed.
  - The threshold is registered alongside the sums.
- Stage 2:
  - det = Sxx·Syy − Sxy·Sxy.
  - tr = Sxx + Syy, then tr2 = tr·tr.
  - All arithmetic is in 64-bit signed.
- Stage 3:
  - kt = (K_NUM·tr2) >>> K_SHIFT, an arithmetic shift, so the result is floored.
  - Rfull = det − kt.
  - R = Rfull clipped to [−2^(R_W−1), 2^(R_W−1)−1].
  - corner = (Rfull > sign-extended threshold), compared before clipping.
  - Q = 1.
- The pipeline has no backpressure. Each stage's valid bit advances every cycle. A new input is accepted on any cycle, including back-to-back cycles.
- R and corner hold their last value while Q = 0. They change only on a cycle when Q = 1.
- corner_count:
  - Increments by 1 on each cycle with Q = 1 and corner = 1.
  - Saturates at 2^CNT_W − 1.
  - When clear_count is asserted on the same cycle as an increment, clear wins and the count becomes 0.

## Timing
- Latency is 3 cycles: start sampled at edge n produces Q = 1 after edge n+3.
- Throughput is 1 result per cycle.
- Reset values: Q = 0, R = 0, corner = 0, corner_count = 0, and all stage valid bits = 0.
- Reset mid-operation discards all in-flight data. No Q pulse appears for inputs accepted in the 3 cycles before reset.
- A start asserted on the same cycle as reset is ignored.
- corner_count reflects a result one cycle after the Q pulse that carries it.

## Configuration
- HARRIS_CORNER_COUNT_EN defined:
  - corner_count and clear_count behave as above.
- HARRIS_CORNER_COUNT_EN undefined:
  - The counter is not built.
  - corner_count is tied to 0 and clear_count is ignored.
  - All other behaviour and latency are unchanged.

## Test plan
- **Zero input.** Reset, then all products = 0, threshold = 0, one start pulse → Q pulses exactly 3 cycles later with R = 0 and corner = 0; count stays 0.
- **Isotropic corner.** All Ixx = 100, Iyy = 100, Ixy = 0, threshold = 500000 → Sxx = Syy = 900, det = 810000, kt = 126562, R = 683438, corner = 1, corner_count = 1.
- **Pure edge.** Ixx = 100, Iyy = 0, Ixy = 0 → det = 0, kt = 31640, R = −31640, corner = 0.
- **Streaming.** Five consecutive start cycles with the corner vector and the edge vector alternating → five consecutive Q cycles in input order with R = 683438, −31640, 683438, −31640, 683438; count increments by 3.
- **Reset mid-flight.** Assert reset 2 cycles after start → no Q pulse ever appears; outputs return to 0.
- **Counter limits.** Set CNT_W = 4 and feed 20 corner inputs → count saturates at 15. Then assert clear_count on the same cycle as a corner Q → count = 0. With HARRIS_CORNER_COUNT_EN undefined → count stays 0 throughout.
